// File: rtl/hyper_delay_pkg.sv
// Shared types for the HyperBus PHY delay-line controller.
// Holds the FSM state encoding and the update-mode encoding.
package hyper_delay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OFF = 2'd1,
      ST_WAIT_ON  = 2'd2,
      ST_RAMP     = 2'd3
   } hyper_delay_state_e;

   localparam logic DLY_MODE_GATED = 1'b0;
   localparam logic DLY_MODE_RAMP  = 1'b1;

endpackage

// File: rtl/hyper_delay_ctrl.sv
// Runtime controller for tap-programmable clock delay lines: applies new codes
// either with the channel clock gated off or by walking one tap at a time.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | ready for a request, all channel clocks enabled
// ST_WAIT_OFF | channel clock gated, settling before the code changes
// ST_WAIT_ON  | new code applied, settling before the clock returns
// ST_RAMP     | code walking toward the target, one tap per settle time
module hyper_delay_ctrl
   import hyper_delay_pkg::*;
#(
   parameter int NumChannels  = 2,
   parameter int DelayWidth   = 4,
   parameter int SettleCycles = 3,
   parameter int ResetDelay   = 0,
   localparam int ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1,
   localparam int CntWidth    = $clog2(SettleCycles + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              cfg_valid_i,
   output logic                              cfg_ready_o,
   input  logic [ChanWidth-1:0]              cfg_chan_i,
   input  logic [DelayWidth-1:0]             cfg_delay_i,
   input  logic                              cfg_ramp_i,
   output logic                              err_o,
   output logic                              busy_o,
   output logic [NumChannels*DelayWidth-1:0] delay_o,
   output logic [NumChannels-1:0]            enable_o
);

   localparam logic [CntWidth-1:0] Reload = CntWidth'(SettleCycles - 1);

   typedef logic [NumChannels-1:0][DelayWidth-1:0] delay_vec_t;

   hyper_delay_state_e      state_q, state_d;
   logic [CntWidth-1:0]     cnt_q, cnt_d;
   logic [ChanWidth-1:0]    chan_q, chan_d;
   logic [DelayWidth-1:0]   target_q, target_d;
   delay_vec_t              delay_q, delay_d;
   logic [NumChannels-1:0]  enable_q, enable_d;
   logic                    err_q, err_d;

   // Steps strictly toward the target, so the code can never wrap.
   function automatic logic [DelayWidth-1:0] step_toward(
      input logic [DelayWidth-1:0] cur,
      input logic [DelayWidth-1:0] tgt
   );
      return (tgt > cur) ? cur + DelayWidth'(1) : cur - DelayWidth'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         chan_q   <= '0;
         target_q <= '0;
         delay_q  <= {NumChannels{DelayWidth'(ResetDelay)}};
         enable_q <= '1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         chan_q   <= chan_d;
         target_q <= target_d;
         delay_q  <= delay_d;
         enable_q <= enable_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      chan_d   = chan_q;
      target_d = target_q;
      delay_d  = delay_q;
      enable_d = enable_q;
      err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid_i) begin
               if (int'(cfg_chan_i) >= NumChannels) begin
                  err_d = 1'b1;
               end else if (cfg_delay_i != delay_q[cfg_chan_i]) begin
                  chan_d   = cfg_chan_i;
                  target_d = cfg_delay_i;
                  cnt_d    = Reload;
                  if (cfg_ramp_i == DLY_MODE_RAMP) begin
                     delay_d[cfg_chan_i] = step_toward(delay_q[cfg_chan_i], cfg_delay_i);
                     state_d = ST_RAMP;
                  end else begin
                     enable_d[cfg_chan_i] = 1'b0;
                     state_d = ST_WAIT_OFF;
                  end
               end
            end
         end
         ST_WAIT_OFF: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntWidth'(1);
            end else begin
               delay_d[chan_q] = target_q;
               cnt_d   = Reload;
               state_d = ST_WAIT_ON;
            end
         end
         ST_WAIT_ON: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntWidth'(1);
            end else begin
               enable_d[chan_q] = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RAMP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntWidth'(1);
            end else if (delay_q[chan_q] == target_q) begin
               state_d = ST_IDLE;
            end else begin
               delay_d[chan_q] = step_toward(delay_q[chan_q], target_q);
               cnt_d = Reload;
            end
         end
      endcase
   end

   assign cfg_ready_o = (state_q == ST_IDLE);
   assign busy_o      = ~cfg_ready_o;
   assign err_o       = err_q;
   assign delay_o     = delay_q;
   assign enable_o    = enable_q;

endmodule

// File: tb/tb_hyper_delay_ctrl.sv
// Directed bench for hyper_delay_ctrl: cycle-exact gated/ramp timelines,
// a table of back-to-back updates, out-of-range channel and mid-update reset.
module tb_hyper_delay_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cfg_valid_i;
   logic        cfg_ready_o;
   logic [0:0]  cfg_chan_i;
   logic [3:0]  cfg_delay_i;
   logic        cfg_ramp_i;
   logic        err_o;
   logic        busy_o;
   logic [7:0]  delay_o;
   logic [1:0]  enable_o;

   logic        valid3;
   logic [1:0]  chan3;
   logic        ready3, err3, busy3;
   logic [11:0] delay3;
   logic [2:0]  en3;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   hyper_delay_ctrl #(
      .NumChannels(2), .DelayWidth(4), .SettleCycles(3), .ResetDelay(5)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_chan_i(cfg_chan_i), .cfg_delay_i(cfg_delay_i), .cfg_ramp_i(cfg_ramp_i),
      .err_o(err_o), .busy_o(busy_o), .delay_o(delay_o), .enable_o(enable_o)
   );

   hyper_delay_ctrl #(
      .NumChannels(3), .DelayWidth(4), .SettleCycles(3), .ResetDelay(5)
   ) dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_valid_i(valid3), .cfg_ready_o(ready3),
      .cfg_chan_i(chan3), .cfg_delay_i(cfg_delay_i), .cfg_ramp_i(cfg_ramp_i),
      .err_o(err3), .busy_o(busy3), .delay_o(delay3), .enable_o(en3)
   );

   typedef struct {
      logic       chan;
      logic [3:0] dly;
      logic       ramp;
      int         busy;
      logic [3:0] d0;
      logic [3:0] d1;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Entered at a negedge; returns busy cycles and whether a ramp misbehaved.
   task automatic run_req(input logic ch, input logic [3:0] dly, input logic ramp,
                          output int busy, output logic glitch);
      logic [3:0] prev, cur;
      int diff;
      prev = ch ? delay_o[7:4] : delay_o[3:0];
      cfg_valid_i = 1'b1;
      cfg_chan_i  = ch;
      cfg_delay_i = dly;
      cfg_ramp_i  = ramp;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      busy   = 0;
      glitch = 1'b0;
      while (1) begin
         cur  = ch ? delay_o[7:4] : delay_o[3:0];
         diff = int'(cur) - int'(prev);
         if (diff < 0) diff = -diff;
         if (ramp && (enable_o !== 2'b11 || diff > 1)) glitch = 1'b1;
         prev = cur;
         if (cfg_ready_o || busy >= 200) break;
         busy++;
         @(negedge clk_i);
      end
   endtask

   initial begin
      int   busy;
      logic glitch;

      vecs[0] = '{1'b0, 4'd2,  1'b1, 0,  4'd2,  4'd12};
      vecs[1] = '{1'b1, 4'd12, 1'b0, 0,  4'd2,  4'd12};
      vecs[2] = '{1'b1, 4'd15, 1'b1, 9,  4'd2,  4'd15};
      vecs[3] = '{1'b1, 4'd0,  1'b1, 45, 4'd2,  4'd0};
      vecs[4] = '{1'b0, 4'd0,  1'b0, 6,  4'd0,  4'd0};
      vecs[5] = '{1'b0, 4'd15, 1'b1, 45, 4'd15, 4'd0};
      vecs[6] = '{1'b1, 4'd7,  1'b0, 6,  4'd15, 4'd7};
      vecs[7] = '{1'b0, 4'd14, 1'b1, 3,  4'd14, 4'd7};
      vecs[8] = '{1'b0, 4'd14, 1'b0, 0,  4'd14, 4'd7};

      rst_ni = 1'b0;
      cfg_valid_i = 1'b0; cfg_chan_i = '0; cfg_delay_i = '0; cfg_ramp_i = 1'b0;
      valid3 = 1'b0; chan3 = '0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      chk("reset_delay",  delay_o,     8'h55);
      chk("reset_enable", enable_o,    2'b11);
      chk("reset_ready",  cfg_ready_o, 1'b1);
      chk("reset_busy",   busy_o,      1'b0);
      chk("reset_err",    err_o,       1'b0);

      // Gated ch1 5 -> 12: gate from E0, code at E0+3, clock back at E0+6.
      cfg_valid_i = 1'b1; cfg_chan_i = 1'b1; cfg_delay_i = 4'd12; cfg_ramp_i = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk_i);
         cfg_valid_i = 1'b0;
         chk($sformatf("gated_en1_k%0d", k),  enable_o[1],  (k < 6) ? 1'b0 : 1'b1);
         chk($sformatf("gated_d1_k%0d", k),   delay_o[7:4], (k >= 3) ? 4'd12 : 4'd5);
         chk($sformatf("gated_rdy_k%0d", k),  cfg_ready_o,  (k >= 6) ? 1'b1 : 1'b0);
         chk($sformatf("gated_busy_k%0d", k), busy_o,       (k >= 6) ? 1'b0 : 1'b1);
         chk($sformatf("gated_ch0_k%0d", k),  {enable_o[0], delay_o[3:0]}, {1'b1, 4'd5});
      end

      // Ramp ch0 5 -> 2: steps at E0, E0+3, E0+6, ready at E0+9.
      cfg_valid_i = 1'b1; cfg_chan_i = 1'b0; cfg_delay_i = 4'd2; cfg_ramp_i = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk_i);
         cfg_valid_i = 1'b0;
         chk($sformatf("ramp_d0_k%0d", k),  delay_o[3:0],
             (k < 3) ? 4'd4 : (k < 6) ? 4'd3 : 4'd2);
         chk($sformatf("ramp_rdy_k%0d", k), cfg_ready_o, (k >= 9) ? 1'b1 : 1'b0);
         chk($sformatf("ramp_en_k%0d", k),  enable_o, 2'b11);
         chk($sformatf("ramp_d1_k%0d", k),  delay_o[7:4], 4'd12);
      end

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].chan, vecs[i].dly, vecs[i].ramp, busy, glitch);
         chk($sformatf("vec%0d_busy", i),   busy, vecs[i].busy);
         chk($sformatf("vec%0d_delay", i),  delay_o, {vecs[i].d1, vecs[i].d0});
         chk($sformatf("vec%0d_enable", i), enable_o, 2'b11);
         chk($sformatf("vec%0d_err", i),    err_o, 1'b0);
         chk($sformatf("vec%0d_ramp", i),   glitch, 1'b0);
      end

      // Out-of-range channel on the three-channel instance.
      valid3 = 1'b1; chan3 = 2'd3; cfg_delay_i = 4'd9; cfg_ramp_i = 1'b0;
      @(negedge clk_i);
      valid3 = 1'b0;
      chk("err_pulse",  err3,   1'b1);
      chk("err_ready",  ready3, 1'b1);
      chk("err_busy",   busy3,  1'b0);
      chk("err_delay",  delay3, 12'h555);
      chk("err_enable", en3,    3'b111);
      @(negedge clk_i);
      chk("err_clear",  err3,   1'b0);
      chk("err_delay2", delay3, 12'h555);

      // Reset in the middle of a gated update.
      cfg_valid_i = 1'b1; cfg_chan_i = 1'b0; cfg_delay_i = 4'd9; cfg_ramp_i = 1'b0;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      chk("mid_gated", enable_o, 2'b10);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_delay",  delay_o,     8'h55);
      chk("mid_rst_enable", enable_o,    2'b11);
      chk("mid_rst_ready",  cfg_ready_o, 1'b1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_req(1'b0, 4'd9, 1'b0, busy, glitch);
      chk("post_rst_busy",   busy,     6);
      chk("post_rst_delay",  delay_o,  8'h59);
      chk("post_rst_enable", enable_o, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
